// File: rtl/rv32i_dec_alu_pc.sv
// rv32i_dec_alu_pc: RV32I ID-stage decoder, EX-stage ALU / branch resolver and fetch PC.
// Optional feature macro: DEC_ILLEGAL_EN adds the id_illegal output.
module rv32i_dec_alu_pc #(
    parameter int unsigned          DATA_LEN = 32,
    parameter int unsigned          INST_LEN = 32,
    parameter int unsigned          ADDR_LEN = 5,
    parameter logic [DATA_LEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INST_LEN-1:0] id_inst,
    output logic [DATA_LEN-1:0] id_imm,
    output logic [ADDR_LEN-1:0] id_rs1_addr,
    output logic [ADDR_LEN-1:0] id_rs2_addr,
    output logic [ADDR_LEN-1:0] id_rd_addr,
    output logic [3:0]          id_alu_fn,
    output logic [2:0]          id_mem_fn,
    output logic [1:0]          id_wb_sel,
    output logic [1:0]          id_rs1_sel,
    output logic [1:0]          id_rs2_sel,
    output logic [2:0]          id_br,
    output logic                id_ecall,
    input  logic [3:0]          ex_alu_fn,
    input  logic [1:0]          ex_rs1_sel,
    input  logic [1:0]          ex_rs2_sel,
    input  logic [2:0]          ex_br,
    input  logic [DATA_LEN-1:0] ex_pc,
    input  logic [DATA_LEN-1:0] ex_rs1_data,
    input  logic [DATA_LEN-1:0] ex_rs2_data,
    input  logic [DATA_LEN-1:0] ex_imm,
    output logic [DATA_LEN-1:0] alu_out,
    output logic                jump_flag,
`ifdef DEC_ILLEGAL_EN
    output logic                id_illegal,
`endif
    input  logic                stall,
    output logic [DATA_LEN-1:0] pc
);

    localparam logic [1:0] SEL_X = 2'd0, SEL1_RS1 = 2'd1, SEL1_PC = 2'd2;
    localparam logic [1:0] SEL2_RS2 = 2'd1, SEL2_IMM = 2'd2;
    localparam logic [1:0] WB_X = 2'd0, WB_ALU = 2'd1, WB_MEM = 2'd2, WB_PC = 2'd3;
    localparam logic [2:0] BR_X = 3'd0, BR_EQ = 3'd1, BR_NE = 3'd2, BR_LT = 3'd3;
    localparam logic [2:0] BR_GE = 3'd4, BR_LTU = 3'd5, BR_GEU = 3'd6, BR_JMP = 3'd7;
    localparam logic [2:0] MEM_LB = 3'd0, MEM_SB = 3'd5;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_JALR = 4'd10;

    localparam logic [6:0] OPC_OP = 7'h33, OPC_OPIMM = 7'h13, OPC_LOAD = 7'h03;
    localparam logic [6:0] OPC_STORE = 7'h23, OPC_BRANCH = 7'h63, OPC_LUI = 7'h37;
    localparam logic [6:0] OPC_AUIPC = 7'h17, OPC_JAL = 7'h6f, OPC_JALR = 7'h67;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       dec_ok;   // instruction recognised as a legal, handled RV32I op
    logic       dec_rs2;  // format carries an rs2 field

    logic [DATA_LEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [DATA_LEN-1:0] src1, src2;

    assign opcode = id_inst[6:0];
    assign funct3 = id_inst[14:12];
    assign funct7 = id_inst[31:25];

    assign imm_i = {{(DATA_LEN-11){id_inst[31]}}, id_inst[30:20]};
    assign imm_s = {{(DATA_LEN-11){id_inst[31]}}, id_inst[30:25], id_inst[11:7]};
    assign imm_b = {{(DATA_LEN-12){id_inst[31]}}, id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0};
    assign imm_u = {{(DATA_LEN-31){id_inst[31]}}, id_inst[30:12], 12'b0};
    assign imm_j = {{(DATA_LEN-20){id_inst[31]}}, id_inst[19:12], id_inst[20], id_inst[30:21],
                    1'b0};

    // funct3 -> ALU op; alt selects SUB/SRA over ADD/SRL
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    // Instruction decode; anything unrecognised (including the bubble) keeps the defaults
    always_comb begin
        id_imm     = '0;
        id_rs1_sel = SEL_X;
        id_rs2_sel = SEL_X;
        id_wb_sel  = WB_X;
        id_mem_fn  = MEM_LB;
        id_alu_fn  = ALU_ADD;
        id_br      = BR_X;
        id_ecall   = 1'b0;
        dec_ok     = 1'b0;
        dec_rs2    = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_ok = (funct7 == 7'h00) ||
                         (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
                if (dec_ok) begin
                    id_rs1_sel = SEL1_RS1;
                    id_rs2_sel = SEL2_RS2;
                    id_wb_sel  = WB_ALU;
                    id_alu_fn  = alu_op(funct3, id_inst[30]);
                    dec_rs2    = 1'b1;
                end
            end
            OPC_OPIMM: begin
                dec_ok = !((funct3 == 3'b001 && funct7 != 7'h00) ||
                           (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20));
                if (dec_ok) begin
                    id_rs1_sel = SEL1_RS1;
                    id_rs2_sel = SEL2_IMM;
                    id_wb_sel  = WB_ALU;
                    id_alu_fn  = alu_op(funct3, funct3 == 3'b101 && id_inst[30]);
                    id_imm     = imm_i;
                end
            end
            OPC_LOAD: begin
                dec_ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                if (dec_ok) begin
                    id_rs1_sel = SEL1_RS1;
                    id_rs2_sel = SEL2_IMM;
                    id_wb_sel  = WB_MEM;
                    // LB/LH/LW keep funct3; LBU/LHU (100/101) map to 3/4
                    id_mem_fn  = funct3[2] ? 3'(funct3 - 3'd1) : funct3;
                    id_imm     = imm_i;
                end
            end
            OPC_STORE: begin
                dec_ok = (funct3 <= 3'b010);
                if (dec_ok) begin
                    id_rs1_sel = SEL1_RS1;
                    id_rs2_sel = SEL2_IMM;
                    id_mem_fn  = 3'(MEM_SB + funct3);
                    id_imm     = imm_s;
                    dec_rs2    = 1'b1;
                end
            end
            OPC_BRANCH: begin
                dec_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
                if (dec_ok) begin
                    id_rs1_sel = SEL1_PC;
                    id_rs2_sel = SEL2_IMM;
                    id_br      = funct3[2] ? 3'(funct3 - 3'd1) : 3'(funct3 + 3'd1);
                    id_imm     = imm_b;
                    dec_rs2    = 1'b1;
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_ok     = 1'b1;
                id_rs1_sel = (opcode == OPC_AUIPC) ? SEL1_PC : SEL_X;
                id_rs2_sel = SEL2_IMM;
                id_wb_sel  = WB_ALU;
                id_imm     = imm_u;
            end
            OPC_JAL: begin
                dec_ok     = 1'b1;
                id_rs1_sel = SEL1_PC;
                id_rs2_sel = SEL2_IMM;
                id_wb_sel  = WB_PC;
                id_br      = BR_JMP;
                id_imm     = imm_j;
            end
            OPC_JALR: begin
                dec_ok = (funct3 == 3'b000);
                if (dec_ok) begin
                    id_rs1_sel = SEL1_RS1;
                    id_rs2_sel = SEL2_IMM;
                    id_wb_sel  = WB_PC;
                    id_alu_fn  = ALU_JALR;
                    id_br      = BR_JMP;
                    id_imm     = imm_i;
                end
            end
            OPC_SYSTEM: begin
                dec_ok   = (id_inst == INST_LEN'(32'h0000_0073));
                id_ecall = dec_ok;
            end
            default: dec_ok = 1'b0;
        endcase
        id_rs1_addr = (id_rs1_sel == SEL1_RS1) ? ADDR_LEN'(id_inst[19:15]) : '0;
        id_rs2_addr = dec_rs2 ? ADDR_LEN'(id_inst[24:20]) : '0;
        id_rd_addr  = (id_wb_sel != WB_X) ? ADDR_LEN'(id_inst[11:7]) : '0;
    end

`ifdef DEC_ILLEGAL_EN
    assign id_illegal = (id_inst != '0) && !dec_ok;
`endif

    // ALU operand selection and function
    always_comb begin
        case (ex_rs1_sel)
            SEL1_RS1: src1 = ex_rs1_data;
            SEL1_PC:  src1 = ex_pc;
            default:  src1 = '0;
        endcase
        case (ex_rs2_sel)
            SEL2_RS2: src2 = ex_rs2_data;
            SEL2_IMM: src2 = ex_imm;
            default:  src2 = '0;
        endcase
        case (ex_alu_fn)
            ALU_ADD:  alu_out = src1 + src2;
            ALU_SUB:  alu_out = src1 - src2;
            ALU_SLL:  alu_out = src1 << src2[4:0];
            ALU_SLT:  alu_out = {{(DATA_LEN-1){1'b0}}, $signed(src1) < $signed(src2)};
            ALU_SLTU: alu_out = {{(DATA_LEN-1){1'b0}}, src1 < src2};
            ALU_XOR:  alu_out = src1 ^ src2;
            ALU_SRL:  alu_out = src1 >> src2[4:0];
            ALU_SRA:  alu_out = $signed(src1) >>> src2[4:0];
            ALU_OR:   alu_out = src1 | src2;
            ALU_AND:  alu_out = src1 & src2;
            ALU_JALR: alu_out = (src1 + src2) & {{(DATA_LEN-1){1'b1}}, 1'b0};
            default:  alu_out = '0;
        endcase
    end

    // Branch resolution on the forwarded register operands
    always_comb begin
        case (ex_br)
            BR_EQ:   jump_flag = (ex_rs1_data == ex_rs2_data);
            BR_NE:   jump_flag = (ex_rs1_data != ex_rs2_data);
            BR_LT:   jump_flag = ($signed(ex_rs1_data) < $signed(ex_rs2_data));
            BR_GE:   jump_flag = ($signed(ex_rs1_data) >= $signed(ex_rs2_data));
            BR_LTU:  jump_flag = (ex_rs1_data < ex_rs2_data);
            BR_GEU:  jump_flag = (ex_rs1_data >= ex_rs2_data);
            BR_JMP:  jump_flag = 1'b1;
            default: jump_flag = 1'b0;
        endcase
    end

    // Fetch PC: reset, then redirect over stall, then sequential step
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (jump_flag) begin
            pc <= alu_out;
        end else if (!stall) begin
            pc <= pc + DATA_LEN'(4);
        end
    end

endmodule

// File: tb/tb_rv32i_dec_alu_pc.sv
// tb_rv32i_dec_alu_pc: directed checks from the test plan plus randomized stimulus
// compared every cycle against an instruction-table reference model.
module tb_rv32i_dec_alu_pc;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id_inst;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]  id_alu_fn;
    logic [2:0]  id_mem_fn;
    logic [1:0]  id_wb_sel, id_rs1_sel, id_rs2_sel;
    logic [2:0]  id_br;
    logic        id_ecall;
    logic [3:0]  ex_alu_fn;
    logic [1:0]  ex_rs1_sel, ex_rs2_sel;
    logic [2:0]  ex_br;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [31:0] alu_out;
    logic        jump_flag;
    logic        stall;
    logic [31:0] pc;
`ifdef DEC_ILLEGAL_EN
    logic        id_illegal;
`endif

    rv32i_dec_alu_pc dut (
        .clk         (clk),
        .reset       (reset),
        .id_inst     (id_inst),
        .id_imm      (id_imm),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_rd_addr  (id_rd_addr),
        .id_alu_fn   (id_alu_fn),
        .id_mem_fn   (id_mem_fn),
        .id_wb_sel   (id_wb_sel),
        .id_rs1_sel  (id_rs1_sel),
        .id_rs2_sel  (id_rs2_sel),
        .id_br       (id_br),
        .id_ecall    (id_ecall),
        .ex_alu_fn   (ex_alu_fn),
        .ex_rs1_sel  (ex_rs1_sel),
        .ex_rs2_sel  (ex_rs2_sel),
        .ex_br       (ex_br),
        .ex_pc       (ex_pc),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_imm      (ex_imm),
        .alu_out     (alu_out),
        .jump_flag   (jump_flag),
`ifdef DEC_ILLEGAL_EN
        .id_illegal  (id_illegal),
`endif
        .stall       (stall),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    // One row per RV32I instruction handled: match pattern and its decoded controls
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        int          fmt;      // 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
        logic [1:0]  s1, s2, wb;
        logic [2:0]  mem;
        logic [3:0]  alu;
        logic [2:0]  br;
        logic        rs2u;
        logic        ec;
    } ent_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic [2:0]  mem;
        logic [1:0]  wb, s1, s2;
        logic [2:0]  br;
        logic        ec;
    } dec_t;

    ent_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic chk_en   = 1'b0;
    logic pc_valid = 1'b0;
    logic [31:0] pc_m;

    localparam logic [31:0] MU = 32'h0000_007f, MI = 32'h0000_707f, MR = 32'hfe00_707f;

    task automatic add(input logic [31:0] mask, input logic [31:0] match, input int fmt,
                       input int s1, input int s2, input int wb, input int mem, input int alu,
                       input int br, input int rs2u, input int ec);
        ent_t e;
        e.mask = mask; e.match = match; e.fmt = fmt;
        e.s1 = 2'(s1); e.s2 = 2'(s2); e.wb = 2'(wb); e.mem = 3'(mem);
        e.alu = 4'(alu); e.br = 3'(br); e.rs2u = rs2u[0]; e.ec = ec[0];
        tbl.push_back(e);
    endtask

    task automatic build_table();
        //   mask  match         fmt s1 s2 wb mem alu br rs2 ec
        add(MU, 32'h0000_0037, 4, 0, 2, 1, 0, 0,  0, 0, 0);  // LUI
        add(MU, 32'h0000_0017, 4, 2, 2, 1, 0, 0,  0, 0, 0);  // AUIPC
        add(MU, 32'h0000_006f, 5, 2, 2, 3, 0, 0,  7, 0, 0);  // JAL
        add(MI, 32'h0000_0067, 1, 1, 2, 3, 0, 10, 7, 0, 0);  // JALR
        add(MI, 32'h0000_0063, 3, 2, 2, 0, 0, 0,  1, 1, 0);  // BEQ
        add(MI, 32'h0000_1063, 3, 2, 2, 0, 0, 0,  2, 1, 0);  // BNE
        add(MI, 32'h0000_4063, 3, 2, 2, 0, 0, 0,  3, 1, 0);  // BLT
        add(MI, 32'h0000_5063, 3, 2, 2, 0, 0, 0,  4, 1, 0);  // BGE
        add(MI, 32'h0000_6063, 3, 2, 2, 0, 0, 0,  5, 1, 0);  // BLTU
        add(MI, 32'h0000_7063, 3, 2, 2, 0, 0, 0,  6, 1, 0);  // BGEU
        add(MI, 32'h0000_0003, 1, 1, 2, 2, 0, 0,  0, 0, 0);  // LB
        add(MI, 32'h0000_1003, 1, 1, 2, 2, 1, 0,  0, 0, 0);  // LH
        add(MI, 32'h0000_2003, 1, 1, 2, 2, 2, 0,  0, 0, 0);  // LW
        add(MI, 32'h0000_4003, 1, 1, 2, 2, 3, 0,  0, 0, 0);  // LBU
        add(MI, 32'h0000_5003, 1, 1, 2, 2, 4, 0,  0, 0, 0);  // LHU
        add(MI, 32'h0000_0023, 2, 1, 2, 0, 5, 0,  0, 1, 0);  // SB
        add(MI, 32'h0000_1023, 2, 1, 2, 0, 6, 0,  0, 1, 0);  // SH
        add(MI, 32'h0000_2023, 2, 1, 2, 0, 7, 0,  0, 1, 0);  // SW
        add(MI, 32'h0000_0013, 1, 1, 2, 1, 0, 0,  0, 0, 0);  // ADDI
        add(MI, 32'h0000_2013, 1, 1, 2, 1, 0, 3,  0, 0, 0);  // SLTI
        add(MI, 32'h0000_3013, 1, 1, 2, 1, 0, 4,  0, 0, 0);  // SLTIU
        add(MI, 32'h0000_4013, 1, 1, 2, 1, 0, 5,  0, 0, 0);  // XORI
        add(MI, 32'h0000_6013, 1, 1, 2, 1, 0, 8,  0, 0, 0);  // ORI
        add(MI, 32'h0000_7013, 1, 1, 2, 1, 0, 9,  0, 0, 0);  // ANDI
        add(MR, 32'h0000_1013, 1, 1, 2, 1, 0, 2,  0, 0, 0);  // SLLI
        add(MR, 32'h0000_5013, 1, 1, 2, 1, 0, 6,  0, 0, 0);  // SRLI
        add(MR, 32'h4000_5013, 1, 1, 2, 1, 0, 7,  0, 0, 0);  // SRAI
        add(MR, 32'h0000_0033, 0, 1, 1, 1, 0, 0,  0, 1, 0);  // ADD
        add(MR, 32'h4000_0033, 0, 1, 1, 1, 0, 1,  0, 1, 0);  // SUB
        add(MR, 32'h0000_1033, 0, 1, 1, 1, 0, 2,  0, 1, 0);  // SLL
        add(MR, 32'h0000_2033, 0, 1, 1, 1, 0, 3,  0, 1, 0);  // SLT
        add(MR, 32'h0000_3033, 0, 1, 1, 1, 0, 4,  0, 1, 0);  // SLTU
        add(MR, 32'h0000_4033, 0, 1, 1, 1, 0, 5,  0, 1, 0);  // XOR
        add(MR, 32'h0000_5033, 0, 1, 1, 1, 0, 6,  0, 1, 0);  // SRL
        add(MR, 32'h4000_5033, 0, 1, 1, 1, 0, 7,  0, 1, 0);  // SRA
        add(MR, 32'h0000_6033, 0, 1, 1, 1, 0, 8,  0, 1, 0);  // OR
        add(MR, 32'h0000_7033, 0, 1, 1, 1, 0, 9,  0, 1, 0);  // AND
        add(32'hffff_ffff, 32'h0000_0073, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // ECALL
    endtask

    // Immediate value by format, assembled arithmetically from the field weights
    function automatic logic [31:0] imm_of(input int fmt, input logic [31:0] i);
        int v;
        case (fmt)
            1: v = int'($signed(i) >>> 20);
            2: v = int'($signed(i) >>> 25) * 32 + int'(i[11:7]);
            3: v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 +
                   int'(i[11:8]) * 2;
            4: v = int'(i & 32'hffff_f000);
            5: v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 +
                   int'(i[30:21]) * 2;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic dec_t dmodel(input logic [31:0] i);
        dec_t d;
        d = '0;
        foreach (tbl[k]) begin
            if ((i & tbl[k].mask) == tbl[k].match) begin
                d.hit = 1'b1;
                d.imm = imm_of(tbl[k].fmt, i);
                d.s1  = tbl[k].s1;  d.s2 = tbl[k].s2;  d.wb = tbl[k].wb;
                d.mem = tbl[k].mem; d.alu = tbl[k].alu; d.br = tbl[k].br;
                d.ec  = tbl[k].ec;
                d.rs1 = (tbl[k].s1 == 2'd1) ? i[19:15] : 5'd0;
                d.rs2 = tbl[k].rs2u ? i[24:20] : 5'd0;
                d.rd  = (tbl[k].wb != 2'd0) ? i[11:7] : 5'd0;
                return d;
            end
        end
        return d;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] a,
                                         input logic [31:0] b);
        return (sel == 2'd1) ? a : (sel == 2'd2) ? b : 32'd0;
    endfunction

    function automatic logic [31:0] alu_model(input logic [3:0] fn, input logic [31:0] a,
                                              input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (fn)
            0:  return a + b;
            1:  return a - b;
            2:  return a << sh;
            3:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4:  return (a < b) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return (a >> sh) | (a[31] ? ~(32'hffff_ffff >> sh) : 32'd0);
            8:  return a | b;
            9:  return a & b;
            10: return (a + b) & 32'hffff_fffe;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic jump_model(input logic [2:0] br, input logic [31:0] a,
                                        input logic [31:0] b);
        logic slt;
        slt = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
        case (br)
            1: return a == b;
            2: return a != b;
            3: return slt;
            4: return !slt;
            5: return a < b;
            6: return a >= b;
            7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] alu_now();
        return alu_model(ex_alu_fn, pick(ex_rs1_sel, ex_rs1_data, ex_pc),
                         pick(ex_rs2_sel, ex_rs2_data, ex_imm));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference PC tracks the registered fetch address
    always @(posedge clk) begin
        if (!reset) begin
            pc_m = 32'h0;
            pc_valid = 1'b1;
        end else if (pc_valid) begin
            if (jump_model(ex_br, ex_rs1_data, ex_rs2_data)) pc_m = alu_now();
            else if (!stall) pc_m = pc_m + 32'd4;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        dec_t d;
        if (chk_en) begin
            d = dmodel(id_inst);
            chk("imm", id_imm, d.imm);
            chk("rs1_addr", 32'(id_rs1_addr), 32'(d.rs1));
            chk("rs2_addr", 32'(id_rs2_addr), 32'(d.rs2));
            chk("rd_addr", 32'(id_rd_addr), 32'(d.rd));
            chk("alu_fn", 32'(id_alu_fn), 32'(d.alu));
            chk("mem_fn", 32'(id_mem_fn), 32'(d.mem));
            chk("wb_sel", 32'(id_wb_sel), 32'(d.wb));
            chk("rs1_sel", 32'(id_rs1_sel), 32'(d.s1));
            chk("rs2_sel", 32'(id_rs2_sel), 32'(d.s2));
            chk("br", 32'(id_br), 32'(d.br));
            chk("ecall", 32'(id_ecall), 32'(d.ec));
`ifdef DEC_ILLEGAL_EN
            chk("illegal", 32'(id_illegal), 32'(id_inst != 32'd0 && !d.hit));
`endif
            chk("alu_out", alu_out, alu_now());
            chk("jump_flag", 32'(jump_flag), 32'(jump_model(ex_br, ex_rs1_data, ex_rs2_data)));
            if (pc_valid) chk("pc", pc, pc_m);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [3:0] fn, input logic [1:0] s1, input logic [1:0] s2,
                          input logic [2:0] br, input logic [31:0] pcv, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] imm);
        ex_alu_fn = fn; ex_rs1_sel = s1; ex_rs2_sel = s2; ex_br = br;
        ex_pc = pcv; ex_rs1_data = r1; ex_rs2_data = r2; ex_imm = imm;
    endtask

    initial begin
        build_table();
        reset = 1'b0;
        stall = 1'b0;
        id_inst = 32'd0;
        set_ex(4'd0, 2'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Reset then sequential fetch
        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        mid();
        chk("reset pc", pc, 32'h0);
        reset = 1'b1;
        next_cycle(); mid(); chk("pc step1", pc, 32'd4);
        next_cycle(); mid(); chk("pc step2", pc, 32'd8);
        next_cycle(); mid(); chk("pc step3", pc, 32'd12);

        // ADDI x5, x1, -3
        next_cycle();
        id_inst = 32'hffd0_8293;
        set_ex(4'd7, 2'd1, 2'd1, 3'd0, 32'd0, 32'h8000_0000, 32'h24, 32'd0);
        mid();
        chk("addi imm", id_imm, 32'hffff_fffd);
        chk("addi rs1", 32'(id_rs1_addr), 32'd1);
        chk("addi rs2", 32'(id_rs2_addr), 32'd0);
        chk("addi rd", 32'(id_rd_addr), 32'd5);
        chk("addi sel", {24'd0, id_rs1_sel, id_rs2_sel, id_wb_sel, 2'd0}, {24'd0, 8'b01_10_01_00});
        chk("addi alu/br", {25'd0, id_alu_fn, id_br}, 32'd0);
        chk("sra", alu_out, 32'hf800_0000);

        next_cycle();
        set_ex(4'd4, 2'd1, 2'd1, 3'd0, 32'd0, 32'd1, 32'hffff_ffff, 32'd0);
        mid();
        chk("sltu", alu_out, 32'd1);

        // Taken BLT with stall: redirect wins
        next_cycle();
        stall = 1'b1;
        set_ex(4'd0, 2'd2, 2'd2, 3'd3, 32'h100, 32'hffff_ffff, 32'd1, 32'h20);
        mid();
        chk("blt jump", 32'(jump_flag), 32'd1);
        chk("blt target", alu_out, 32'h120);
        next_cycle(); mid();
        chk("blt pc", pc, 32'h120);

        // Same operands unsigned: not taken, stall holds
        next_cycle();
        ex_br = 3'd5;
        mid();
        chk("bltu jump", 32'(jump_flag), 32'd0);
        next_cycle(); mid(); chk("stall hold1", pc, 32'h120);
        next_cycle(); mid(); chk("stall hold2", pc, 32'h120);

        // JALR clears bit 0
        next_cycle();
        stall = 1'b0;
        set_ex(4'd10, 2'd1, 2'd2, 3'd7, 32'h0, 32'h1003, 32'd0, 32'd0);
        mid();
        chk("jalr target", alu_out, 32'h1002);
        chk("jalr jump", 32'(jump_flag), 32'd1);
        next_cycle(); mid(); chk("jalr pc", pc, 32'h1002);

        // Reset beats a pending jump under stall
        next_cycle();
        stall = 1'b1;
        reset = 1'b0;
        next_cycle(); mid(); chk("reset mid-jump", pc, 32'h0);
        reset = 1'b1;
        stall = 1'b0;

        // Bubble and ecall
        next_cycle();
        id_inst = 32'd0;
        mid();
        chk("bubble ctl", {15'd0, id_imm[0], id_rd_addr, id_alu_fn, id_wb_sel, id_rs1_sel,
                           id_br}, 32'd0);
        chk("bubble imm", id_imm, 32'd0);
        next_cycle();
        id_inst = 32'h0000_0073;
        mid();
        chk("ecall", 32'(id_ecall), 32'd1);
        chk("ecall wb", 32'(id_wb_sel), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            next_cycle();
            r = $urandom_range(0, 99);
            if (r < 60) begin
                int unsigned k;
                k = $urandom_range(0, tbl.size() - 1);
                id_inst = ($urandom & ~tbl[k].mask) | tbl[k].match;
            end else if (r < 90) id_inst = $urandom;
            else if (r < 95) id_inst = 32'd0;
            else id_inst = 32'h0000_0073;
            ex_alu_fn   = 4'($urandom_range(0, 15));
            ex_rs1_sel  = 2'($urandom_range(0, 3));
            ex_rs2_sel  = 2'($urandom_range(0, 3));
            ex_br       = 3'($urandom_range(0, 7));
            ex_pc       = $urandom & 32'hffff_fffc;
            ex_rs1_data = $urandom;
            ex_rs2_data = ($urandom_range(0, 3) == 0) ? ex_rs1_data : $urandom;
            ex_imm      = $urandom;
            stall       = ($urandom_range(0, 2) == 0);
            reset       = ($urandom_range(0, 49) != 0);
        end
        next_cycle();
        mid();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
